// File: rtl/stopwatch_rate_controller_if.sv
// Command, divider and status signals between the stopwatch sequencer and its requesters.
// Each requester holds req with stable cmd/val until its one-cycle ack; there is no other backpressure.
interface stopwatch_rate_controller_if #(
    parameter int CNT_W = 16
);
    logic             loc_req;
    logic [1:0]       loc_cmd;
    logic [3:0]       loc_val;
    logic             loc_ack;
    logic             net_req;
    logic [1:0]       net_cmd;
    logic [3:0]       net_val;
    logic             net_ack;
    logic             div_clk;
    logic [3:0]       set_val;
    logic             tick;
    logic [CNT_W-1:0] tick_count;
    logic             clr_pulse;
    logic [1:0]       state;

    modport master (
        output loc_req, loc_cmd, loc_val, net_req, net_cmd, net_val, div_clk,
        input  loc_ack, net_ack, set_val, tick, tick_count, clr_pulse, state
    );

    modport slave (
        input  loc_req, loc_cmd, loc_val, net_req, net_cmd, net_val, div_clk,
        output loc_ack, net_ack, set_val, tick, tick_count, clr_pulse, state
    );
endinterface

// File: rtl/stopwatch_rate_controller.sv
// Round-robin run/stop/speed/clear sequencer with divider-edge tick generation; one-cycle command and tick latency.
// Requesters hold req until ack; the ack cycle masks a held req, so one requester can issue at most every other cycle.
module stopwatch_rate_controller #(
    parameter int MAX_SPEED     = 9,
    parameter int DEFAULT_SPEED = 5,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    stopwatch_rate_controller_if.slave   bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_SPEED = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    localparam logic GRANT_LOC = 1'b0;
    localparam logic GRANT_NET = 1'b1;

    localparam logic [3:0] MAX_CODE     = 4'(MAX_SPEED);
    localparam logic [3:0] DEFAULT_CODE = 4'(DEFAULT_SPEED);

    logic [1:0]       state_q;
    logic [3:0]       speed_q;
    logic [CNT_W-1:0] count_q;
    logic             tick_q;
    logic             clr_q;
    logic             loc_ack_q;
    logic             net_ack_q;
    logic             div_q;
    logic             last_grant;

    logic             loc_elig;
    logic             net_elig;
    logic             grant_loc;
    logic             grant_net;
    logic             any_grant;
    logic [1:0]       cmd;
    logic [3:0]       val;
    logic [1:0]       state_nxt;
    logic [3:0]       speed_nxt;
    logic             is_clear;
    logic             tick_nxt;

    always_comb begin
        loc_elig  = bus.loc_req & ~loc_ack_q;
        net_elig  = bus.net_req & ~net_ack_q;
        // On a tie the side that did not win last time takes the grant.
        grant_loc = loc_elig & (~net_elig | (last_grant == GRANT_NET));
        grant_net = net_elig & ~grant_loc;
        any_grant = grant_loc | grant_net;
        cmd       = grant_loc ? bus.loc_cmd : bus.net_cmd;
        val       = grant_loc ? bus.loc_val : bus.net_val;
        is_clear  = any_grant & (cmd == CMD_CLEAR);
        // Tick decision uses the state before this edge's command.
        tick_nxt  = (state_q == ST_RUNNING) & bus.div_clk & ~div_q;

        state_nxt = state_q;
        speed_nxt = speed_q;
        if (any_grant) begin
            case (cmd)
                CMD_START: state_nxt = ST_RUNNING;
                CMD_STOP:  if (state_q == ST_RUNNING) state_nxt = ST_PAUSED;
                CMD_SPEED: speed_nxt = (val > MAX_CODE) ? MAX_CODE : val;
                default:   state_nxt = ST_IDLE;
            endcase
        end
        if (state_q == 2'd3) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            speed_q    <= DEFAULT_CODE;
            count_q    <= '0;
            tick_q     <= 1'b0;
            clr_q      <= 1'b0;
            loc_ack_q  <= 1'b0;
            net_ack_q  <= 1'b0;
            div_q      <= 1'b0;
            last_grant <= GRANT_NET;
        end else begin
            state_q   <= state_nxt;
            speed_q   <= speed_nxt;
            tick_q    <= tick_nxt;
            clr_q     <= is_clear;
            loc_ack_q <= grant_loc;
            net_ack_q <= grant_net;
            div_q     <= bus.div_clk;
            if (any_grant) last_grant <= grant_net;
            // A clear on the same edge as a tick wins; that tick is not counted.
            if (is_clear) begin
                count_q <= '0;
            end else if (tick_nxt) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.set_val    = speed_q;
    assign bus.tick       = tick_q;
    assign bus.tick_count = count_q;
    assign bus.clr_pulse  = clr_q;
    assign bus.loc_ack    = loc_ack_q;
    assign bus.net_ack    = net_ack_q;
endmodule

// File: tb/tb_stopwatch_rate_controller.sv
// Directed bench for the stopwatch sequencer: stimulus queues expected acks and ticks, a negedge monitor pops and checks them.
// Narrow counter instance so the wrap boundary is reachable in a short run.
module tb_stopwatch_rate_controller;
    localparam int CNT_W = 8;

    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_STOP  = 2'd1;
    localparam logic [1:0] C_SPEED = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    typedef struct packed {
        logic       is_net;
        logic [1:0] state;
        logic [3:0] set_val;
        logic       clr;
    } ack_exp_t;

    logic clk = 1'b0;
    logic reset;

    stopwatch_rate_controller_if #(.CNT_W(CNT_W)) bus ();

    stopwatch_rate_controller #(
        .MAX_SPEED     (9),
        .DEFAULT_SPEED (5),
        .CNT_W         (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ack_exp_t         ack_q[$];
    logic [CNT_W-1:0] tick_q[$];
    ack_exp_t         mon_e;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.loc_ack || bus.net_ack) begin
            chk("single_ack", int'(bus.loc_ack & bus.net_ack), 0);
            chk("ack_expected", int'(ack_q.size() > 0), 1);
            if (ack_q.size() > 0) begin
                mon_e = ack_q.pop_front();
                chk("ack_who", int'(bus.net_ack), int'(mon_e.is_net));
                chk("ack_state", int'(bus.state), int'(mon_e.state));
                chk("ack_set_val", int'(bus.set_val), int'(mon_e.set_val));
                chk("ack_clr_pulse", int'(bus.clr_pulse), int'(mon_e.clr));
            end
        end
        if (bus.clr_pulse) chk("clr_with_ack", int'(bus.loc_ack | bus.net_ack), 1);
        if (bus.tick) begin
            chk("tick_expected", int'(tick_q.size() > 0), 1);
            if (tick_q.size() > 0) chk("tick_count_at_tick", int'(bus.tick_count), int'(tick_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic is_net, input logic [1:0] cmd, input logic [3:0] val,
                         input logic [1:0] exp_state, input logic [3:0] exp_speed, input logic exp_clr);
        int waited = 0;
        ack_q.push_back(ack_exp_t'{is_net, exp_state, exp_speed, exp_clr});
        if (is_net) begin
            bus.net_req = 1'b1; bus.net_cmd = cmd; bus.net_val = val;
        end else begin
            bus.loc_req = 1'b1; bus.loc_cmd = cmd; bus.loc_val = val;
        end
        do begin
            step();
            waited++;
        end while (!(is_net ? bus.net_ack : bus.loc_ack) && waited < 10);
        chk(is_net ? "net_ack_latency" : "loc_ack_latency", waited, 1);
        bus.loc_req = 1'b0;
        bus.net_req = 1'b0;
        step();
    endtask

    task automatic div_pulse(input int hi, input int lo, input int exp_count);
        if (exp_count >= 0) tick_q.push_back(CNT_W'(exp_count));
        bus.div_clk = 1'b1;
        repeat (hi) step();
        bus.div_clk = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.loc_req = 1'b0; bus.loc_cmd = 2'd0; bus.loc_val = 4'd0;
        bus.net_req = 1'b0; bus.net_cmd = 2'd0; bus.net_val = 4'd0;
        bus.div_clk = 1'b0;

        // Reset with the divider toggling.
        repeat (2) begin
            bus.div_clk = ~bus.div_clk;
            step();
        end
        chk("rst_state", int'(bus.state), 0);
        chk("rst_set_val", int'(bus.set_val), 5);
        chk("rst_tick_count", int'(bus.tick_count), 0);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_loc_ack", int'(bus.loc_ack), 0);
        chk("rst_net_ack", int'(bus.net_ack), 0);
        chk("rst_clr_pulse", int'(bus.clr_pulse), 0);
        bus.div_clk = 1'b0;
        reset = 1'b0;
        step();

        // Basic run: START, three divider rises, STOP, then no more ticks.
        issue(1'b0, C_START, 4'd0, 2'd1, 4'd5, 1'b0);
        div_pulse(2, 2, 1);
        div_pulse(2, 2, 2);
        div_pulse(2, 2, 3);
        chk("run_tick_count", int'(bus.tick_count), 3);
        issue(1'b1, C_STOP, 4'd0, 2'd2, 4'd5, 1'b0);
        div_pulse(2, 2, -1);
        chk("paused_tick_count", int'(bus.tick_count), 3);
        chk("paused_state", int'(bus.state), 2);

        // Round-robin tie with both requesters held for four edges.
        ack_q.push_back(ack_exp_t'{1'b0, 2'd2, 4'd2, 1'b0});
        ack_q.push_back(ack_exp_t'{1'b1, 2'd2, 4'd7, 1'b0});
        ack_q.push_back(ack_exp_t'{1'b0, 2'd2, 4'd2, 1'b0});
        ack_q.push_back(ack_exp_t'{1'b1, 2'd2, 4'd7, 1'b0});
        bus.loc_req = 1'b1; bus.loc_cmd = C_SPEED; bus.loc_val = 4'd2;
        bus.net_req = 1'b1; bus.net_cmd = C_SPEED; bus.net_val = 4'd7;
        repeat (4) step();
        bus.loc_req = 1'b0;
        bus.net_req = 1'b0;
        repeat (2) step();
        chk("rr_all_acked", ack_q.size(), 0);
        chk("rr_final_set_val", int'(bus.set_val), 7);

        // Speed saturation and zero.
        issue(1'b0, C_SPEED, 4'd12, 2'd2, 4'd9, 1'b0);
        chk("sat_set_val", int'(bus.set_val), 9);
        issue(1'b1, C_SPEED, 4'd0, 2'd2, 4'd0, 1'b0);
        chk("zero_set_val", int'(bus.set_val), 0);

        // Clear, run up to 0xFE, then CLEAR on the same edge as a divider rise.
        issue(1'b0, C_CLEAR, 4'd0, 2'd0, 4'd0, 1'b1);
        chk("clear_tick_count", int'(bus.tick_count), 0);
        issue(1'b1, C_START, 4'd0, 2'd1, 4'd0, 1'b0);
        for (int i = 1; i <= 254; i++) div_pulse(1, 1, i);
        chk("pre_collision_count", int'(bus.tick_count), 254);
        ack_q.push_back(ack_exp_t'{1'b0, 2'd0, 4'd0, 1'b1});
        tick_q.push_back(CNT_W'(0));
        bus.loc_req = 1'b1; bus.loc_cmd = C_CLEAR; bus.loc_val = 4'd0;
        bus.div_clk = 1'b1;
        step();
        bus.loc_req = 1'b0;
        bus.div_clk = 1'b0;
        chk("collision_tick_count", int'(bus.tick_count), 0);
        chk("collision_state", int'(bus.state), 0);
        step();
        chk("clr_pulse_one_cycle", int'(bus.clr_pulse), 0);

        // Wrap: 254 ticks to 0xFE, then two more land on 0xFF and 0x00.
        issue(1'b1, C_START, 4'd0, 2'd1, 4'd0, 1'b0);
        for (int i = 1; i <= 254; i++) div_pulse(1, 1, i);
        div_pulse(1, 1, 255);
        div_pulse(1, 1, 0);
        chk("wrap_tick_count", int'(bus.tick_count), 0);

        // Reset on the grant edge of a pending START.
        bus.net_req = 1'b1; bus.net_cmd = C_START; bus.net_val = 4'd0;
        reset = 1'b1;
        step();
        chk("midreset_net_ack", int'(bus.net_ack), 0);
        chk("midreset_state", int'(bus.state), 0);
        reset = 1'b0;
        bus.net_req = 1'b0;
        step();
        chk("postreset_net_ack", int'(bus.net_ack), 0);
        chk("postreset_set_val", int'(bus.set_val), 5);
        issue(1'b1, C_START, 4'd0, 2'd1, 4'd5, 1'b0);
        chk("restart_state", int'(bus.state), 1);

        repeat (3) step();
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("tick_queue_drained", tick_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_rate_controller.md
# stopwatch_rate_controller

Command sequencer for the stopwatch timebase. Arbitrates run/stop/speed/clear commands from the local button path and the Ethernet command path, drives the 4-bit `set_val` speed code into the variable clock divider, and converts the divider's output into single-cycle `tick` enables while running. Also keeps an elapsed-tick count for the display and Ethernet status paths.

## Interface
- `MAX_SPEED`, 9: highest legal speed code; larger requested values saturate to this.
- `DEFAULT_SPEED`, 5: `set_val` after reset.
- `CNT_W`, 16: width of `tick_count`.

- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `loc_req` in 1: local requester command valid, held high until `loc_ack`.
- `loc_cmd` in 2: local command: 0 START, 1 STOP, 2 SET_SPEED, 3 CLEAR.
- `loc_val` in 4: speed code for SET_SPEED; ignored for other commands.
- `loc_ack` out 1: one-cycle pulse, local command executed.
- `net_req`, `net_cmd[1:0]`, `net_val[3:0]`, `net_ack`: Ethernet requester, identical semantics.
- `div_clk` in 1: divider output, synchronous to `clk`.
- `set_val` out 4: speed code to the divider.
- `tick` out 1: one-cycle pulse per `div_clk` rising edge while RUNNING.
- `tick_count` out CNT_W: ticks since the last CLEAR.
- `clr_pulse` out 1: one-cycle pulse on CLEAR execution.
- `state` out 2: 0 IDLE, 1 RUNNING, 2 PAUSED.

## Operation
- Reset values: `state` = IDLE, `set_val` = DEFAULT_SPEED, `tick_count` = 0. `tick`, `clr_pulse`, `loc_ack`, and `net_ack` are all 0. Internal `div_q` = 0 and `last_grant` = NET.
- Eligibility: a requester is eligible when its `req` is high and its `ack` is not high this cycle. The ack cycle masks the request, so a held `req` cannot execute twice back-to-back.
- Arbitration: at most one command executes per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester that is not `last_grant` wins (round-robin).
  - After reset, LOC wins the first tie.
  - `last_grant` updates on every grant.
- Execution happens at the clock edge where the grant is decided. The matching `ack` is high for exactly the next cycle.
- State transitions:
  - START: IDLE→RUNNING, PAUSED→RUNNING; in RUNNING it is a no-op that is still acked.
  - STOP: RUNNING→PAUSED; in IDLE or PAUSED it is a no-op that is still acked.
  - CLEAR: any state→IDLE. `tick_count` is set to 0 and `clr_pulse` is high the next cycle.
  - SET_SPEED: `set_val` is set to min(`val`, MAX_SPEED). Legal in any state. `state` is unchanged.
  - State 3 is unreachable; if it is ever decoded, the next state is IDLE.
- Tick generation:
  - `div_q` is set to `div_clk` every cycle.
  - `tick` is set to (`state`==RUNNING) & `div_clk` & ~`div_q`, using `state` before this edge's command is applied.
  - `tick_count` increments by 1 on every cycle where `tick` is high. It wraps from 2^CNT_W−1 to 0.
- Simultaneous events:
  - CLEAR and a tick in the same cycle: CLEAR wins, and `tick_count` = 0 (the tick is not counted).
  - STOP in the same cycle as a `div_clk` edge: the tick is still issued, because it uses the pre-edge state.
  - START coinciding with an edge produces no tick.
- Requests are not queued. A deasserted `req` before grant is simply dropped. `cmd` and `val` must be stable while `req` is high.
- Reset mid-handshake: the pending command is discarded and no `ack` is issued. The requester must re-request after reset.

## Timing
- Command latency: `req` sampled high at edge N with a grant means the effect is visible and `ack` is high during cycle N→N+1. Minimum spacing between commands from one requester is 2 cycles.
- When both requesters are held high, grants alternate every cycle: LOC, NET, LOC, ...
- Tick latency: if `div_clk` is first sampled high at edge N, `tick` is high for cycle N→N+1. There is exactly one pulse per `div_clk` high phase.
- `set_val` changes are visible one cycle after the grant edge. The divider period changes at its next wrap; this block does not resynchronise it.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset behaviour: assert `reset` for 2 cycles with `div_clk` toggling. Required: `state`=0, `set_val`=5, `tick_count`=0, and no `tick`, `ack`, or `clr_pulse`.
- Basic run: `loc_cmd`=START, then let `div_clk` rise 3 times, then `net_cmd`=STOP. Required: `loc_ack` 1 cycle after grant, 3 `tick` pulses, `tick_count`=3, `state`=2, and no ticks after the STOP edge.
- Round-robin tie: hold `loc_req` and `net_req` both high with SET_SPEED, `loc_val`=2 and `net_val`=7, for 4 cycles. Required: grant order LOC, NET, LOC, NET. `set_val` goes 2, 7, 2, 7. Each ack is 1 cycle wide, with no consecutive acks to the same requester.
- Saturation: SET_SPEED with `val`=12. Required: `set_val`=9. SET_SPEED with `val`=0 gives `set_val`=0.
- CLEAR collision: while RUNNING with `tick_count`=0xFFFE, CLEAR on the same edge as a `div_clk` rise. Required: `tick_count`=0, `state`=0, `clr_pulse`=1 for 1 cycle. Separately, 2 ticks from 0xFFFE wrap `tick_count` to 0x0000.
- Reset mid-operation: raise `net_req` with START, then assert `reset` on the grant edge. Required: no `net_ack`, `state`=0, and a fresh START after reset executes normally.
